// File: rtl/a8_phase_tracker_if.sv
// a8_phase_tracker bus bundle: phi2 input, strobe offsets
// and the tracker's status and strobe outputs.
`timescale 1ns/1ps
interface a8_phase_tracker_if #(
  parameter int CNT_W       = 8,
  parameter int NUM_STROBES = 4
);
  logic                         a8_clk;
  logic [NUM_STROBES*CNT_W-1:0] strobe_offset;
  logic [NUM_STROBES-1:0]       strobe;
  logic                         rise_pulse;
  logic                         fall_pulse;
  logic [CNT_W-1:0]             phase;
  logic [CNT_W-1:0]             period;
  logic                         period_valid;
  logic                         clk_lost;

  modport master (
    output a8_clk, strobe_offset,
    input  strobe, rise_pulse, fall_pulse,
    input  phase, period, period_valid, clk_lost
  );

  modport slave (
    input  a8_clk, strobe_offset,
    output strobe, rise_pulse, fall_pulse,
    output phase, period, period_valid, clk_lost
  );
endinterface

// File: rtl/a8_phase_tracker.sv
// Atari phi2 monitor: period measurement, lock/loss tracking
// and programmable per-bus-cycle phase strobes.
`timescale 1ns/1ps
module a8_phase_tracker #(
  parameter int SYNC_STAGES  = 3,
  parameter int CNT_W        = 8,
  parameter int LOSS_TICKS   = 200,
  parameter int LOCK_PERIODS = 4,
  parameter int TOL          = 2,
  parameter int NUM_STROBES  = 4
) (
  input logic             clk200,
  input logic             a8_rst_n,
  a8_phase_tracker_if.slave bus
);

  localparam int MW = $clog2(LOCK_PERIODS + 1);
  localparam logic [CNT_W-1:0] LOSS_V = CNT_W'(LOSS_TICKS);
  localparam logic [CNT_W:0]   TOL_V  = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0]    LAST_M = MW'(LOCK_PERIODS - 1);
  localparam logic [CNT_W-1:0] SAT    = '1;

  typedef enum logic [1:0] {
    LOST,
    ACQUIRE,
    LOCKED
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       phase_q;
  logic [CNT_W-1:0]       period_q;
  state_t                 state_q;
  logic [MW-1:0]          match_q;
  logic                   have_ref_q;
  logic                   valid_q;
  logic                   lost_q;

  logic [CNT_W:0] meas;
  logic [CNT_W:0] diff;
  logic [CNT_W:0] adiff;
  logic           in_tol;
  logic           lost_hit;

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a8_clk};
      rise_q <= sync_q[SYNC_STAGES-2]
              & ~sync_q[SYNC_STAGES-1];
      fall_q <= ~sync_q[SYNC_STAGES-2]
              & sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      phase_q <= '0;
    end else if (rise_q) begin
      phase_q <= '0;
    end else if (phase_q != SAT) begin
      phase_q <= phase_q + 1'b1;
    end
  end

  // Signed difference at CNT_W+1 bits, then magnitude.
  always_comb begin
    meas     = {1'b0, phase_q} + (CNT_W+1)'(1);
    diff     = meas - {1'b0, period_q};
    adiff    = diff[CNT_W] ? (~diff + 1'b1) : diff;
    in_tol   = adiff <= TOL_V;
    lost_hit = (phase_q >= LOSS_V) && !rise_q;
  end

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      state_q    <= LOST;
      period_q   <= '0;
      match_q    <= '0;
      have_ref_q <= 1'b0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b1;
    end else if (lost_hit) begin
      state_q <= LOST;
      valid_q <= 1'b0;
      lost_q  <= 1'b1;
    end else if (rise_q) begin
      unique case (state_q)
        LOST: begin
          state_q    <= ACQUIRE;
          match_q    <= '0;
          have_ref_q <= 1'b0;
          lost_q     <= 1'b0;
        end
        ACQUIRE: begin
          period_q <= meas[CNT_W-1:0];
          if (!have_ref_q) begin
            have_ref_q <= 1'b1;
          end else if (in_tol) begin
            match_q <= match_q + 1'b1;
            if (match_q == LAST_M) begin
              state_q <= LOCKED;
              valid_q <= 1'b1;
            end
          end else begin
            match_q <= '0;
          end
        end
        LOCKED: begin
          period_q <= meas[CNT_W-1:0];
          if (!in_tol) begin
            state_q <= ACQUIRE;
            match_q <= '0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= LOST;
          valid_q <= 1'b0;
          lost_q  <= 1'b1;
        end
      endcase
    end
  end

  // Offsets are compared live; one at or past period cannot fire.
  for (genvar i = 0; i < NUM_STROBES; i++) begin : g_strb
    logic [CNT_W-1:0] off;
    assign off = bus.strobe_offset[i*CNT_W +: CNT_W];
    assign bus.strobe[i] = valid_q
                         && (phase_q == off)
                         && (off < period_q);
  end

  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.phase        = phase_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.clk_lost     = lost_q;

endmodule

// File: tb/tb_a8_phase_tracker.sv
// Directed bench for a8_phase_tracker: lock, strobes,
// tolerance, loss, coincident rise and async reset.
`timescale 1ns/1ps
module tb_a8_phase_tracker;

  logic clk200;
  logic a8_rst_n;
  int   n_chk;
  int   n_err;
  int   off [4];

  a8_phase_tracker_if #(.CNT_W(8), .NUM_STROBES(4)) bus ();

  a8_phase_tracker dut (
    .clk200   (clk200),
    .a8_rst_n (a8_rst_n),
    .bus      (bus)
  );

  initial clk200 = 1'b0;
  always #2.5 clk200 = ~clk200;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_offs();
    bus.strobe_offset = {off[3][7:0], off[2][7:0],
                         off[1][7:0], off[0][7:0]};
  endtask

  function automatic int exp_strb(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++)
      if (k == off[i] && off[i] < 112) r |= (1 << i);
    return r;
  endfunction

  task automatic cyc(input logic v);
    @(posedge clk200);
    #1;
    bus.a8_clk = v;
  endtask

  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic run_s(input logic v, input int n,
                       input int ph0);
    for (int i = 0; i < n; i++) begin
      cyc(v);
      chk("strobe_ph", int'(bus.strobe), exp_strb(ph0 + i));
    end
  endtask

  task automatic period_rest(input int lo);
    run(1'b1, 51);
    run(1'b0, lo);
    run(1'b1, 4);
    run(1'b1, 1);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_strobe"}, int'(bus.strobe), 0);
    chk({tag, "_rise"}, int'(bus.rise_pulse), 0);
    chk({tag, "_fall"}, int'(bus.fall_pulse), 0);
    chk({tag, "_phase"}, int'(bus.phase), 0);
    chk({tag, "_period"}, int'(bus.period), 0);
    chk({tag, "_valid"}, int'(bus.period_valid), 0);
    chk({tag, "_lost"}, int'(bus.clk_lost), 1);
  endtask

  task automatic acquire();
    run(1'b0, 5);
    run(1'b1, 4);
    chk("r1_rise", int'(bus.rise_pulse), 1);
    chk("r1_lost_hold", int'(bus.clk_lost), 1);
    run(1'b1, 1);
    chk("r1_rise_end", int'(bus.rise_pulse), 0);
    chk("r1_lost", int'(bus.clk_lost), 0);
    chk("r1_phase0", int'(bus.phase), 0);
    run(1'b1, 51);
    run(1'b0, 3);
    chk("fall_pre", int'(bus.fall_pulse), 0);
    run(1'b0, 1);
    chk("fall", int'(bus.fall_pulse), 1);
    run(1'b0, 1);
    chk("fall_end", int'(bus.fall_pulse), 0);
    run(1'b0, 51);
    run(1'b1, 4);
    chk("r2_phase", int'(bus.phase), 111);
    run(1'b1, 1);
    chk("r2_period", int'(bus.period), 112);
    chk("r2_valid", int'(bus.period_valid), 0);
    for (int r = 3; r <= 5; r++) period_rest(56);
    chk("r5_valid", int'(bus.period_valid), 0);
    run(1'b1, 51);
    run(1'b0, 56);
    run(1'b1, 4);
    chk("r6_valid_hold", int'(bus.period_valid), 0);
    run(1'b1, 1);
    chk("r6_valid", int'(bus.period_valid), 1);
    chk("r6_strobe", int'(bus.strobe), exp_strb(0));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    off[0] = 0;
    off[1] = 10;
    off[2] = 60;
    off[3] = 111;
    set_offs();
    bus.a8_clk = 1'b0;
    a8_rst_n = 1'b1;
    #1;
    a8_rst_n = 1'b0;
    #2;
    reset_chk("rst");
    #8;
    a8_rst_n = 1'b1;

    acquire();

    // two full locked bus cycles, strobe checked every tick
    run_s(1'b1, 51, 1);
    run_s(1'b0, 56, 52);
    run_s(1'b1, 4, 108);
    run_s(1'b1, 1, 0);
    off[3] = 150;
    set_offs();
    run_s(1'b1, 51, 1);
    run_s(1'b0, 56, 52);
    run_s(1'b1, 4, 108);
    run_s(1'b1, 1, 0);

    period_rest(58);
    chk("t114_period", int'(bus.period), 114);
    chk("t114_valid", int'(bus.period_valid), 1);
    period_rest(56);
    chk("t112_period", int'(bus.period), 112);
    chk("t112_valid", int'(bus.period_valid), 1);
    run(1'b1, 51);
    run(1'b0, 60);
    run(1'b1, 4);
    chk("t116_valid_hold", int'(bus.period_valid), 1);
    run(1'b1, 1);
    chk("t116_valid", int'(bus.period_valid), 0);
    chk("t116_period", int'(bus.period), 116);
    chk("t116_strobe", int'(bus.strobe), 0);
    for (int r = 1; r <= 4; r++) begin
      period_rest(60);
      chk("relock_valid", int'(bus.period_valid),
          (r == 4) ? 1 : 0);
    end

    run(1'b1, 150);
    chk("loss_ph150_strobe", int'(bus.strobe), 0);
    run(1'b1, 49);
    chk("loss_ph199", int'(bus.phase), 199);
    chk("loss_pre", int'(bus.clk_lost), 0);
    run(1'b1, 1);
    chk("loss_ph200", int'(bus.phase), 200);
    chk("loss_trig", int'(bus.clk_lost), 0);
    chk("loss_trig_valid", int'(bus.period_valid), 1);
    run(1'b1, 1);
    chk("loss_lost", int'(bus.clk_lost), 1);
    chk("loss_valid", int'(bus.period_valid), 0);
    chk("loss_ph201", int'(bus.phase), 201);
    run(1'b1, 60);
    chk("loss_sat", int'(bus.phase), 255);

    run(1'b0, 10);
    run(1'b1, 4);
    chk("restart_rise", int'(bus.rise_pulse), 1);
    chk("restart_hold", int'(bus.clk_lost), 1);
    run(1'b1, 1);
    chk("restart_lost", int'(bus.clk_lost), 0);
    chk("restart_valid", int'(bus.period_valid), 0);
    chk("restart_period", int'(bus.period), 116);

    run(1'b1, 51);
    run(1'b0, 145);
    run(1'b1, 4);
    chk("sim_phase", int'(bus.phase), 200);
    chk("sim_rise", int'(bus.rise_pulse), 1);
    run(1'b1, 1);
    chk("sim_lost", int'(bus.clk_lost), 0);
    chk("sim_period", int'(bus.period), 201);

    for (int r = 1; r <= 5; r++) period_rest(56);
    chk("pre_rst_valid", int'(bus.period_valid), 1);
    run(1'b1, 10);
    #0.5;
    a8_rst_n = 1'b0;
    bus.a8_clk = 1'b0;
    #2;
    reset_chk("midrst");
    #1;
    a8_rst_n = 1'b1;
    acquire();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/a8_phase_tracker.md
# a8_phase_tracker

Parametrised successor to the single-counter Atari bus clock monitor. It runs in the `clk200` domain and does the following:
- synchronises `a8_clk` and measures its period in `clk200` ticks;
- qualifies lock over several consecutive periods and detects clock loss;
- emits `NUM_STROBES` programmable one-cycle phase strobes per bus cycle.

Downstream bus-snoop logic uses these strobes to sample address and data at fixed offsets after the φ2 rising edge.

## Interface
- `SYNC_STAGES`, 3: synchroniser depth on `a8_clk`; minimum 2.
- `CNT_W`, 8: width of the phase counter and of `period`.
- `LOSS_TICKS`, 200: phase count at which the clock is declared lost; must be < 2^CNT_W.
- `LOCK_PERIODS`, 4: consecutive matching periods required to lock.
- `TOL`, 2: maximum allowed absolute difference between successive periods, in ticks.
- `NUM_STROBES`, 4: number of strobe channels.

Ports:
- `clk200`  in  1: system clock. Every flop is clocked by its rising edge.
- `a8_rst_n`  in  1: reset, asynchronous and active-low.
- `a8_clk`  in  1: asynchronous Atari φ2 input.
- `strobe_offset`  in  NUM_STROBES*CNT_W: per-channel phase offset; channel i uses bits [i*CNT_W +: CNT_W].
- `strobe`  out  NUM_STROBES: one-cycle strobe pulses.
- `rise_pulse`  out  1: one-cycle pulse on each synchronised `a8_clk` rising edge.
- `fall_pulse`  out  1: one-cycle pulse on each synchronised `a8_clk` falling edge.
- `phase`  out  CNT_W: clk200 ticks since the last rise.
- `period`  out  CNT_W: last accepted period measurement.
- `period_valid`  out  1: high while the block is in LOCKED.
- `clk_lost`  out  1: high while the block is in LOST.

## Operation
- **Synchroniser:** shift register `s[0..SYNC_STAGES-1]`, loaded from `a8_clk`.
  - `rise_pulse = s[N-2] & ~s[N-1]`.
  - `fall_pulse = ~s[N-2] & s[N-1]`.
  - Both are registered outputs.
- **Phase counter:**
  - Loads 0 in the cycle after `rise_pulse`.
  - Otherwise increments by 1.
  - Saturates at 2^CNT_W-1 and never wraps.
- **State machine:** states LOST (reset state), ACQUIRE, LOCKED.
  - LOST → ACQUIRE: on `rise_pulse`. `match_cnt` is cleared and `have_ref` is cleared.
  - ACQUIRE, on `rise_pulse` with `have_ref` = 0: the measured value `phase+1` is stored as `period` and `have_ref` is set.
  - ACQUIRE, on `rise_pulse` with `have_ref` = 1:
    - If |(phase+1) − period| <= TOL, `match_cnt` increments. Otherwise `match_cnt` is cleared.
    - In both cases `period` is updated to `phase+1`.
    - When `match_cnt` reaches LOCK_PERIODS, the state moves to LOCKED.
  - LOCKED, on `rise_pulse`:
    - If the deviation is <= TOL, `period` is updated and the state stays LOCKED.
    - Otherwise the state moves to ACQUIRE, `match_cnt` is cleared, and `period` is updated.
  - Any state → LOST: when `phase` >= LOSS_TICKS and `rise_pulse` is low.
  - Simultaneous `rise_pulse` and `phase` >= LOSS_TICKS: the rise wins and no loss is flagged.
- **Difference arithmetic:** the period difference is computed at CNT_W+1 bits, signed, and then made absolute.
- **Strobes:**
  - `strobe[i]` is high for exactly one cycle when state == LOCKED and `phase` == `strobe_offset[i]`.
  - An offset >= `period` never fires.
  - Offsets are used live, with no internal capture. Software changes them only while `period_valid` = 0.
- **Outputs after reset:**
  - `strobe`, `rise_pulse`, `fall_pulse`, `phase`, `period`, `period_valid` = 0.
  - `clk_lost` = 1.
  - Synchroniser flops, `match_cnt` and `have_ref` = 0.

## Timing
- **Edge latency:** `a8_clk` is first sampled high at clk200 edge k. `rise_pulse` is then high during the cycle after edge k+SYNC_STAGES-1.
  - This is 3 cycles for the default depth.
- **Phase after a rise:** `phase` = 0 in the cycle after `rise_pulse`, then 1, 2, and so on.
- **Status latency:** `period_valid`, `clk_lost` and `period` change in the cycle after the triggering `rise_pulse`.
  - For loss detection, the trigger is the `phase` = LOSS_TICKS cycle instead of `rise_pulse`.
- **Strobe timing:** a strobe is coincident with the `phase` value it matches; it adds no latency.
- **Asynchronous reset:** asserting `a8_rst_n` forces every register to its reset value immediately, mid-cycle, in any state.
  - Deassertion is synchronised externally.
  - The first edge detected after reset may be partial. Its period is used only as the reference, never as a match.

## Test plan
- **Lock acquisition:** reset, then `a8_clk` at 112-tick period (56 high / 56 low).
  - 1st rise → ACQUIRE; `clk_lost` = 0.
  - 2nd rise → `period` = 112.
  - Lock occurs at the 6th rise, with `period_valid` = 1 one cycle later.
- **Strobe placement:** locked at 112 ticks with offsets 0, 10, 60, 111.
  - Each strobe pulses once per bus cycle at exactly `phase` 0, 10, 60 and 111.
  - Changing channel 3's offset to 150 → channel 3 is silent.
- **Tolerance:** while locked, a period of 114 keeps the block LOCKED.
  - A period of 116 → ACQUIRE, `period_valid` = 0 next cycle, strobes stop.
  - 4 further periods of 116 → relock.
- **Clock loss:** hold `a8_clk` high while locked.
  - `clk_lost` = 1 one cycle after `phase` reaches 200.
  - `period_valid` = 0, and `phase` saturates at 255.
  - A restarted clock → ACQUIRE.
- **Simultaneous events:** an `a8_clk` rise arrives so that `rise_pulse` coincides with `phase` = 200.
  - The block remains out of LOST and `period` = 201.
- **Mid-operation reset:** pulse `a8_rst_n` low for 3 ns while locked.
  - All outputs take their reset values without waiting for a `clk200` edge.
  - After release, the full acquisition sequence repeats.
